// File: rtl/eth_decap.sv
// Receive-side UDP/TCAP decapsulator: validates the 48-byte Eth/IPv4/UDP/TCAP
// header, strips it and forwards TLP payload beats to the TLP FIFO.
module eth_decap #(
  parameter logic [47:0] eth_addr  = 48'h00_11_22_33_44_55,
  parameter logic [31:0] ip_addr   = {8'd192, 8'd168, 8'd11, 8'd1},
  parameter logic [15:0] udp_dport = 16'h3776,
  parameter logic [2:0]  tcap_ver  = 3'b001
) (
  input  logic        clk156,
  input  logic        sys_rst,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic        wr_en,
  output logic [73:0] din,
  input  logic        full,
  output logic [39:0] rx_seq,
  output logic [31:0] rx_pkt_cnt,
  output logic [31:0] rx_drop_cnt,
  output logic [15:0] rx_gap_cnt
);

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    DATA = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [2:0]  beat_cnt_r;
  logic [2:0]  beat_cnt_nxt_s;
  logic        bad_r;
  logic        bad_nxt_s;
  logic [15:0] daddr_hi_r;
  logic        seen_r;
  logic        field_ok_s;
  logic        beat_ok_s;
  logic        accept_s;
  logic        drop_s;
  logic        daddr_ld_s;
  logic        tready_s;
  logic        wr_en_s;
  logic [47:0] h_dest_s;
  logic [39:0] seq_s;

  // Wire order is MSB first, byte 0 of the beat sits in tdata[7:0].
  assign h_dest_s = {s_axis_tdata[7:0],   s_axis_tdata[15:8],  s_axis_tdata[23:16],
                     s_axis_tdata[31:24], s_axis_tdata[39:32], s_axis_tdata[47:40]};
  assign seq_s    = {s_axis_tdata[31:24], s_axis_tdata[39:32], s_axis_tdata[47:40],
                     s_axis_tdata[55:48], s_axis_tdata[63:56]};

  // Per-beat header field check selected by the header beat index
  always_comb begin
    field_ok_s = 1'b0;
    case (beat_cnt_r)
      3'd0: field_ok_s = (h_dest_s == eth_addr) || (h_dest_s == 48'hFFFF_FFFF_FFFF);
      3'd1: field_ok_s = (s_axis_tdata[39:32] == 8'h08) && (s_axis_tdata[47:40] == 8'h00) &&
                         (s_axis_tdata[55:48] == 8'h45);
      3'd2: field_ok_s = (s_axis_tdata[63:56] == 8'h11);
      3'd3: field_ok_s = 1'b1;
      3'd4: field_ok_s = ({daddr_hi_r, s_axis_tdata[7:0], s_axis_tdata[15:8]} == ip_addr) &&
                         ({s_axis_tdata[39:32], s_axis_tdata[47:40]} == udp_dport);
      3'd5: field_ok_s = (s_axis_tdata[23:21] == tcap_ver);
      default: field_ok_s = 1'b0;
    endcase
    beat_ok_s = field_ok_s && (s_axis_tkeep == 8'hFF) && !s_axis_tuser;
  end

  // Next-state, handshake and statistic strobes
  always_comb begin
    state_nxt_s    = state_r;
    beat_cnt_nxt_s = beat_cnt_r;
    bad_nxt_s      = bad_r;
    accept_s       = 1'b0;
    drop_s         = 1'b0;
    daddr_ld_s     = 1'b0;
    tready_s       = 1'b0;
    wr_en_s        = 1'b0;
    case (state_r)
      HDR: begin
        tready_s = 1'b1;
        if (s_axis_tvalid) begin
          daddr_ld_s = (beat_cnt_r == 3'd3);
          if (s_axis_tlast) begin
            drop_s         = 1'b1;
            beat_cnt_nxt_s = 3'd0;
            bad_nxt_s      = 1'b0;
          end else if (beat_cnt_r == 3'd5) begin
            beat_cnt_nxt_s = 3'd0;
            bad_nxt_s      = 1'b0;
            if (bad_r || !beat_ok_s) begin
              state_nxt_s = DROP;
              drop_s      = 1'b1;
            end else begin
              state_nxt_s = DATA;
              accept_s    = 1'b1;
            end
          end else begin
            beat_cnt_nxt_s = beat_cnt_r + 3'd1;
            bad_nxt_s      = bad_r || !beat_ok_s;
          end
        end else begin
          state_nxt_s = HDR;
        end
      end
      DATA: begin
        tready_s = !full;
        wr_en_s  = s_axis_tvalid && !full;
        if (s_axis_tvalid && !full && s_axis_tlast) begin
          state_nxt_s = HDR;
        end else begin
          state_nxt_s = DATA;
        end
      end
      DROP: begin
        tready_s = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          state_nxt_s = HDR;
        end else begin
          state_nxt_s = DROP;
        end
      end
      default: begin
        state_nxt_s    = HDR;
        beat_cnt_nxt_s = 3'd0;
        bad_nxt_s      = 1'b0;
      end
    endcase
  end

  // Handshake and FIFO word are forced quiet while reset is asserted.
  assign s_axis_tready = tready_s && !sys_rst;
  assign wr_en         = wr_en_s && !sys_rst;
  assign din           = ((state_r == DATA) && !sys_rst) ?
                         {s_axis_tkeep, s_axis_tdata, s_axis_tlast, s_axis_tuser} : 74'd0;

  // Parser state register
  always_ff @(posedge clk156 or posedge sys_rst) begin
    if (sys_rst) begin
      state_r    <= HDR;
      beat_cnt_r <= 3'd0;
      bad_r      <= 1'b0;
      daddr_hi_r <= 16'd0;
    end else begin
      state_r    <= state_nxt_s;
      beat_cnt_r <= beat_cnt_nxt_s;
      bad_r      <= bad_nxt_s;
      if (daddr_ld_s) begin
        daddr_hi_r <= {s_axis_tdata[55:48], s_axis_tdata[63:56]};
      end
    end
  end

  // Receive statistics and sequence-gap tracking
  always_ff @(posedge clk156 or posedge sys_rst) begin
    if (sys_rst) begin
      rx_seq      <= 40'd0;
      rx_pkt_cnt  <= 32'd0;
      rx_drop_cnt <= 32'd0;
      rx_gap_cnt  <= 16'd0;
      seen_r      <= 1'b0;
    end else begin
      if (drop_s) begin
        rx_drop_cnt <= rx_drop_cnt + 32'd1;
      end
      if (accept_s) begin
        rx_pkt_cnt <= rx_pkt_cnt + 32'd1;
        rx_seq     <= seq_s;
        seen_r     <= 1'b1;
        if (seen_r && (seq_s != rx_seq + 40'd1)) begin
          rx_gap_cnt <= rx_gap_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_eth_decap.sv
// Self-checking bench for eth_decap: vector table, hand-written corner cases and
// randomized frames against a byte-level reference model.
`timescale 1ns/1ps
module tb_eth_decap;

  logic        clk156 = 1'b0;
  logic        sys_rst;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tlast;
  logic        s_axis_tuser;
  logic        wr_en;
  logic [73:0] din;
  logic        full;
  logic [39:0] rx_seq;
  logic [31:0] rx_pkt_cnt;
  logic [31:0] rx_drop_cnt;
  logic [15:0] rx_gap_cnt;

  eth_decap dut (
    .clk156(clk156), .sys_rst(sys_rst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .wr_en(wr_en), .din(din), .full(full),
    .rx_seq(rx_seq), .rx_pkt_cnt(rx_pkt_cnt),
    .rx_drop_cnt(rx_drop_cnt), .rx_gap_cnt(rx_gap_cnt)
  );

  always #3.2 clk156 = ~clk156;

  localparam logic [47:0] MAC   = 48'h00_11_22_33_44_55;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [31:0] IP    = {8'd192, 8'd168, 8'd11, 8'd1};

  int checks = 0;
  int errors = 0;

  logic full_force = 1'b0;
  logic full_rnd_en = 1'b0;
  logic full_rnd = 1'b0;
  assign full = full_force | full_rnd;

  always @(posedge clk156) begin
    #1;
    full_rnd <= full_rnd_en ? ($urandom_range(3) == 0) : 1'b0;
  end

  logic [73:0] act_q[$];
  logic [73:0] exp_q[$];
  int full_viol = 0;

  always @(negedge clk156) begin
    if (wr_en === 1'b1) begin
      act_q.push_back(din);
      if (full) full_viol++;
    end
  end

  logic [63:0] fr_data[$];
  logic [7:0]  fr_keep[$];
  logic        fr_user[$];

  int unsigned m_pkt, m_drop;
  logic [15:0] m_gap;
  logic [39:0] m_seq;
  logic        m_seen;

  typedef struct {
    logic [47:0] dest;
    logic [31:0] daddr;
    logic [15:0] dport;
    logic [7:0]  proto;
    logic [2:0]  ver;
    logic [39:0] seq;
    int          nbeats;
    int          err_beat;
    logic        exp_acc;
    int          exp_writes;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_pkt = 0; m_drop = 0; m_gap = 16'd0; m_seq = 40'd0; m_seen = 1'b0;
  endfunction

  // Lay the header out byte by byte in wire order, then pack into beats.
  function automatic void build(input logic [47:0] dest, input logic [31:0] daddr,
                                input logic [15:0] dport, input logic [7:0] proto,
                                input logic [2:0] ver, input logic [39:0] seq,
                                input int nbeats, input int err_beat);
    logic [7:0]  b[48];
    logic [63:0] w;
    for (int i = 0; i < 48; i++) b[i] = 8'h00;
    for (int i = 0; i < 6; i++) b[i] = dest[47-8*i -: 8];
    b[6] = 8'h02; b[11] = 8'h01; b[12] = 8'h08; b[13] = 8'h00;
    b[14] = 8'h45; b[22] = 8'h40; b[23] = proto;
    b[26] = 8'hC0; b[27] = 8'hA8; b[28] = 8'h0B; b[29] = 8'h02;
    for (int i = 0; i < 4; i++) b[30+i] = daddr[31-8*i -: 8];
    b[34] = 8'h37; b[35] = 8'h77; b[36] = dport[15:8]; b[37] = dport[7:0];
    b[42] = {ver, 5'b00000};
    for (int i = 0; i < 5; i++) b[43+i] = seq[39-8*i -: 8];
    fr_data.delete(); fr_keep.delete(); fr_user.delete();
    for (int j = 0; j < nbeats; j++) begin
      if (j < 6) begin
        for (int k = 0; k < 8; k++) w[8*k +: 8] = b[8*j+k];
        fr_keep.push_back(8'hFF);
      end else begin
        w = {$urandom, $urandom};
        fr_keep.push_back((j == nbeats - 1) ? (8'hFF >> $urandom_range(7)) : 8'hFF);
      end
      fr_data.push_back(w);
      fr_user.push_back(j == err_beat);
    end
  endfunction

  // Reference: decide the frame's fate from its header bytes and update stats.
  function automatic void model_frame();
    int          n;
    logic        ok;
    logic [7:0]  b[48];
    logic [47:0] dest;
    logic [39:0] seq;
    n  = fr_data.size();
    ok = (n >= 7);
    for (int i = 0; i < 48; i++) b[i] = (i / 8 < n) ? fr_data[i/8][8*(i%8) +: 8] : 8'h00;
    for (int j = 0; j < 6 && j < n; j++) if (fr_keep[j] != 8'hFF || fr_user[j]) ok = 1'b0;
    dest = {b[0], b[1], b[2], b[3], b[4], b[5]};
    if (dest != MAC && dest != BCAST) ok = 1'b0;
    if ({b[12], b[13]} != 16'h0800 || b[14] != 8'h45 || b[23] != 8'h11) ok = 1'b0;
    if ({b[30], b[31], b[32], b[33]} != IP) ok = 1'b0;
    if ({b[36], b[37]} != 16'h3776) ok = 1'b0;
    if (b[42][7:5] != 3'b001) ok = 1'b0;
    seq = {b[43], b[44], b[45], b[46], b[47]};
    if (ok) begin
      m_pkt++;
      if (m_seen && seq != m_seq + 40'd1) m_gap++;
      m_seq  = seq;
      m_seen = 1'b1;
      for (int j = 6; j < n; j++)
        exp_q.push_back({fr_keep[j], fr_data[j], (j == n - 1), fr_user[j]});
    end else begin
      m_drop++;
    end
  endfunction

  // Send the first nb beats of the current frame; optionally hold full for
  // stall_len cycles while beat stall_at is presented.
  task automatic send(input int gap_pct, input int stall_at, input int stall_len,
                      input int nb, output int stalls);
    int  budget;
    logic acc;
    stalls = 0;
    for (int i = 0; i < nb; i++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        s_axis_tvalid = 1'b0;
        @(posedge clk156); #1;
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = fr_data[i];
      s_axis_tkeep  = fr_keep[i];
      s_axis_tlast  = (i == fr_data.size() - 1);
      s_axis_tuser  = fr_user[i];
      if (i == stall_at) begin
        full_force = 1'b1;
        for (int c = 0; c < stall_len; c++) begin
          @(negedge clk156);
          chk("stall_tready", s_axis_tready, 1'b0);
          chk("stall_wr_en", wr_en, 1'b0);
          @(posedge clk156); #1;
        end
        full_force = 1'b0;
        @(negedge clk156);
        chk("resume_tready", s_axis_tready, 1'b1);
        chk("resume_wr_en", wr_en, 1'b1);
        @(posedge clk156); #1;
      end else begin
        acc = 1'b0;
        budget = 0;
        while (!acc) begin
          @(negedge clk156);
          acc = s_axis_tready;
          if (!acc) stalls++;
          @(posedge clk156); #1;
          budget++;
          if (!acc && budget > 200) begin
            chk("handshake_timeout", 1'b1, 1'b0);
            acc = 1'b1;
          end
        end
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic check_stats(input string tag);
    int n;
    chk({tag, "_pkt"},  rx_pkt_cnt,  m_pkt);
    chk({tag, "_drop"}, rx_drop_cnt, m_drop);
    chk({tag, "_gap"},  rx_gap_cnt,  m_gap);
    chk({tag, "_seq"},  rx_seq,      m_seq);
    chk({tag, "_nwr"},  act_q.size(), exp_q.size());
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_din"}, act_q[i], exp_q[i]);
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
    repeat (2) @(posedge clk156);
    #1;
    sys_rst = 1'b0;
    model_reset();
    act_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int st;
    int unsigned pkt0;
    logic [47:0] d;
    logic [39:0] sq;
    logic [39:0] seqs[4];

    sys_rst = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tdata = 64'd0; s_axis_tkeep = 8'd0;
    s_axis_tlast = 1'b0;  s_axis_tuser = 1'b0;
    model_reset();

    //            dest   daddr  dport      proto  ver     seq                nb  err acc  wr
    vecs[0]  = '{MAC,   IP,    16'h3776, 8'h11, 3'b001, 40'd1,             10, -1, 1'b1, 4};
    vecs[1]  = '{MAC,   IP,    16'h1234, 8'h11, 3'b001, 40'd2,             10, -1, 1'b0, 0};
    vecs[2]  = '{MAC,   IP,    16'h3776, 8'h11, 3'b001, 40'd2,              3, -1, 1'b0, 0};
    vecs[3]  = '{MAC,   IP,    16'h3776, 8'h11, 3'b001, 40'd2,              7, -1, 1'b1, 1};
    vecs[4]  = '{MAC,   IP,    16'h3776, 8'h11, 3'b001, 40'd3,              6, -1, 1'b0, 0};
    vecs[5]  = '{BCAST, IP,    16'h3776, 8'h11, 3'b001, 40'd3,              9,  2, 1'b0, 0};
    vecs[6]  = '{BCAST, IP,    16'h3776, 8'h11, 3'b001, 40'hFF_FFFF_FFFF,   8, -1, 1'b1, 2};
    vecs[7]  = '{48'h001122334456, IP, 16'h3776, 8'h11, 3'b001, 40'd0,     8, -1, 1'b0, 0};
    vecs[8]  = '{MAC,   IP,    16'h3776, 8'h06, 3'b001, 40'd0,              8, -1, 1'b0, 0};
    vecs[9]  = '{MAC,   IP,    16'h3776, 8'h11, 3'b010, 40'd0,              8, -1, 1'b0, 0};
    vecs[10] = '{MAC,   32'hC0A80B02, 16'h3776, 8'h11, 3'b001, 40'd0,       8, -1, 1'b0, 0};
    vecs[11] = '{MAC,   IP,    16'h3776, 8'h11, 3'b001, 40'd0,             11,  8, 1'b1, 5};

    repeat (3) @(posedge clk156);
    @(negedge clk156);
    chk("rst_tready", s_axis_tready, 1'b0);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_din", din, 74'd0);
    chk("rst_pkt", rx_pkt_cnt, 32'd0);
    chk("rst_drop", rx_drop_cnt, 32'd0);
    chk("rst_gap", rx_gap_cnt, 16'd0);
    chk("rst_seq", rx_seq, 40'd0);
    @(posedge clk156); #1;
    sys_rst = 1'b0;

    // Table-driven frames
    for (int v = 0; v < 12; v++) begin
      pkt0 = rx_pkt_cnt;
      build(vecs[v].dest, vecs[v].daddr, vecs[v].dport, vecs[v].proto, vecs[v].ver,
            vecs[v].seq, vecs[v].nbeats, vecs[v].err_beat);
      model_frame();
      send(0, -1, 0, fr_data.size(), st);
      chk($sformatf("vec%0d_acc", v), rx_pkt_cnt - pkt0, vecs[v].exp_acc);
      chk($sformatf("vec%0d_writes", v), act_q.size(), vecs[v].exp_writes);
      if (!vecs[v].exp_acc) chk($sformatf("vec%0d_no_stall", v), st, 0);
      check_stats($sformatf("vec%0d", v));
    end

    // full held for three cycles on payload beat 2
    build(MAC, IP, 16'h3776, 8'h11, 3'b001, 40'd10, 10, -1);
    model_frame();
    send(0, 8, 3, fr_data.size(), st);
    check_stats("stall");

    // Sequence gap scenario
    do_reset();
    seqs[0] = 40'd1; seqs[1] = 40'd2; seqs[2] = 40'd5; seqs[3] = 40'd6;
    for (int i = 0; i < 4; i++) begin
      build(MAC, IP, 16'h3776, 8'h11, 3'b001, seqs[i], 8, -1);
      model_frame();
      send(0, -1, 0, fr_data.size(), st);
    end
    chk("gap_cnt", rx_gap_cnt, 16'd1);
    chk("gap_seq", rx_seq, 40'd6);
    chk("gap_pkt", rx_pkt_cnt, 32'd4);
    check_stats("gap");

    // Reset asserted mid-payload, then the leftover beats arrive as a frame
    build(MAC, IP, 16'h3776, 8'h11, 3'b001, 40'd7, 10, -1);
    send(0, -1, 0, 8, st);
    s_axis_tvalid = 1'b1; s_axis_tdata = fr_data[8]; s_axis_tkeep = fr_keep[8];
    s_axis_tlast = 1'b0;  s_axis_tuser = fr_user[8];
    #2;
    sys_rst = 1'b1;
    #1;
    chk("midrst_tready", s_axis_tready, 1'b0);
    chk("midrst_wr_en", wr_en, 1'b0);
    chk("midrst_din", din, 74'd0);
    chk("midrst_pkt", rx_pkt_cnt, 32'd0);
    chk("midrst_seq", rx_seq, 40'd0);
    @(posedge clk156); #1;
    sys_rst = 1'b0;
    model_reset();
    act_q.delete();
    exp_q.delete();
    repeat (8) begin
      void'(fr_data.pop_front());
      void'(fr_keep.pop_front());
      void'(fr_user.pop_front());
    end
    model_frame();
    send(0, -1, 0, fr_data.size(), st);
    check_stats("midrst");

    // Randomized frames with idle gaps and random back-pressure
    full_rnd_en = 1'b1;
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(5))
        0: d = 48'h001122334456;
        1: d = BCAST;
        default: d = MAC;
      endcase
      sq = ($urandom_range(3) == 0) ? {8'hFF, $urandom} : m_seq + 40'd1;
      build(d,
            ($urandom_range(9) == 0) ? 32'hC0A80B07 : IP,
            ($urandom_range(9) == 0) ? 16'h3777 : 16'h3776,
            ($urandom_range(9) == 0) ? 8'h06 : 8'h11,
            ($urandom_range(9) == 0) ? 3'b010 : 3'b001,
            sq, $urandom_range(14, 1),
            ($urandom_range(7) == 0) ? $urandom_range(13) : -1);
      model_frame();
      send(20, -1, 0, fr_data.size(), st);
      check_stats($sformatf("rnd%0d", it));
    end
    full_rnd_en = 1'b0;
    repeat (2) @(posedge clk156);
    chk("write_while_full", full_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
